edge_detect: RTL and testbench

// - Per-bit rising, falling and any-edge detector for a level signal, sampled in the clk domain.
// - Used by timers and peripherals to turn an external clock or strobe into one-cycle pulses.
// - Example: a PIT counter clock input becomes a count-enable pulse.
// - Pulses are valid in the cycle the new level is first seen at the detector input.

---
 rtl/edge_detect.sv | 65 ++++++
 tb/tb_edge_detect.sv | 137 +++++++++++++
 2 files changed

// File: rtl/edge_detect.sv
// ============================================================================
// Module   : edge_detect
// Brief    : Per-bit rising/falling/any-edge detector with optional input
//            synchronizer (enabled by defining EDGE_DET_SYNC_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_detect #(
  parameter int WID         = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  input  logic [WID-1:0] i,
  output logic [WID-1:0] pe,
  output logic [WID-1:0] ne,
  output logic [WID-1:0] ee
);

  if (SYNC_STAGES < 2) begin : g_sync_depth_invalid
    $error("edge_detect: SYNC_STAGES must be at least 2");
  end

  logic [WID-1:0] w_d;
  logic [WID-1:0] r_hist;

`ifdef EDGE_DET_SYNC_EN
  // Chain runs every cycle regardless of ce so metastability settling is never stalled.
  logic [WID-1:0] r_sync [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= '0;
      end
    end else begin
      r_sync[0] <= i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_d = r_sync[SYNC_STAGES-1];
`else
  assign w_d = i;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist <= '0;
    end else if (ce) begin
      r_hist <= w_d;
    end
  end

  assign pe = w_d & ~r_hist;
  assign ne = ~w_d & r_hist;
  assign ee = w_d ^ r_hist;

endmodule

`default_nettype wire

// File: tb/tb_edge_detect.sv
// Randomized self-checking bench for edge_detect against a per-bit level-tracking model.
`default_nettype none

module tb_edge_detect;

  localparam int WID         = 4;
  localparam int SYNC_STAGES = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           ce  = 1'b1;
  logic [WID-1:0] i   = '0;
  logic [WID-1:0] pe;
  logic [WID-1:0] ne;
  logic [WID-1:0] ee;

  int checks = 0;
  int errors = 0;

  edge_detect #(
    .WID        (WID),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ce (ce),
    .i  (i),
    .pe (pe),
    .ne (ne),
    .ee (ee)
  );

  always #5 clk = ~clk;

  // Model state: last level acknowledged per bit, and the input delay line.
  logic           m_seen [WID];
  logic [WID-1:0] m_pipe [$];

  task automatic check(input string tag, input logic [WID-1:0] got, input logic [WID-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WID-1:0] model_d();
`ifdef EDGE_DET_SYNC_EN
    return m_pipe[0];
`else
    return i;
`endif
  endfunction

  task automatic model_reset();
    for (int b = 0; b < WID; b++) m_seen[b] = 1'b0;
    m_pipe.delete();
    for (int k = 0; k < SYNC_STAGES; k++) m_pipe.push_back('0);
  endtask

  // One clock: drive at negedge, compare mid-cycle, advance the model at posedge.
  task automatic step(input logic r, input logic c, input logic [WID-1:0] v, input string tag);
    logic [WID-1:0] d;
    logic [WID-1:0] exp_pe;
    logic [WID-1:0] exp_ne;
    logic [WID-1:0] exp_ee;
    @(negedge clk);
    rst = r;
    ce  = c;
    i   = v;
    #1;
    d      = model_d();
    exp_pe = '0;
    exp_ne = '0;
    exp_ee = '0;
    for (int b = 0; b < WID; b++) begin
      if (d[b] != m_seen[b]) begin
        exp_ee[b] = 1'b1;
        if (d[b]) exp_pe[b] = 1'b1;
        else      exp_ne[b] = 1'b1;
      end
    end
    check({tag, ".pe"}, pe, exp_pe);
    check({tag, ".ne"}, ne, exp_ne);
    check({tag, ".ee"}, ee, exp_ee);
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (c) begin
        for (int b = 0; b < WID; b++) m_seen[b] = d[b];
      end
      m_pipe.push_back(i);
      void'(m_pipe.pop_front());
    end
  endtask

  initial begin
    model_reset();
    // Reset state with quiet input.
    repeat (3) step(1'b1, 1'b1, 4'b0000, "reset");
    // Single rising edge, then steady, then falling edge.
    repeat (2) step(1'b0, 1'b1, 4'b0000, "idle");
    repeat (4) step(1'b0, 1'b1, 4'b0001, "rise");
    repeat (4) step(1'b0, 1'b1, 4'b0000, "fall");
    // Reset held with input high: reset-high input is seen as a rising edge.
    repeat (3) step(1'b1, 1'b1, 4'b1111, "rst_hi");
    repeat (3) step(1'b0, 1'b1, 4'b1111, "rel_hi");
    // ce low freezes history so a change stays asserted.
    repeat (2) step(1'b0, 1'b1, 4'b0000, "pre_ce");
    repeat (4) step(1'b0, 1'b0, 4'b0011, "ce_low");
    repeat (3) step(1'b0, 1'b1, 4'b0011, "ce_back");
    // Multi-bit alternating patterns and per-cycle toggling.
    step(1'b0, 1'b1, 4'b0000, "pat0");
    repeat (SYNC_STAGES) step(1'b0, 1'b1, 4'b0000, "pat0");
    for (int n = 0; n < 8; n++) begin
      step(1'b0, 1'b1, n[0] ? 4'b1010 : 4'b0101, "toggle");
    end
    // Randomized traffic with occasional reset and ce gaps.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           WID'($urandom), "rand");
    end
    // Slow-changing random levels so edges are sparse.
    for (int n = 0; n < 200; n++) begin
      logic [WID-1:0] v;
      v = i;
      if ($urandom_range(0, 3) == 0) v[$urandom_range(0, WID-1)] = ~v[$urandom_range(0, WID-1)];
      step(1'b0, ($urandom_range(0, 5) != 0), v, "slow");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
